alu_rs_scheduler: RTL and testbench

- Reservation station and issue scheduler for the shared integer ALU in the out-of-order core.
- Buffers decoded ALU-class instructions (arithmetic, branch-compare, lui/auipc/jal) and captures operands from the CDB.
- Each cycle it selects one ready entry, drives the combinational ALU inputs from registers, then registers the ALU result with its ROB tag for CDB broadcast.

---
 rtl/alu_rs_scheduler.sv | 175 +++++++++++++++++
 tb/tb_alu_rs_scheduler.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_scheduler.sv
// Reservation station and issue scheduler for the shared integer ALU.
// Holds decoded ALU-class instructions, wakes operands from the CDB,
// dispatches the lowest-index ready entry each cycle into a registered
// ALU input stage, and registers the ALU result with its ROB tag.
module alu_rs_scheduler #(
  parameter int RS_SIZE   = 8,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 issue_valid_in,
  input  logic [5:0]           issue_op_in,
  input  logic [31:0]          issue_vj_in,
  input  logic [ROB_WIDTH-1:0] issue_qj_in,
  input  logic                 issue_qj_busy_in,
  input  logic [31:0]          issue_vk_in,
  input  logic [ROB_WIDTH-1:0] issue_qk_in,
  input  logic                 issue_qk_busy_in,
  input  logic [ROB_WIDTH-1:0] issue_dest_in,
  output logic                 full_out,
  input  logic                 cdb_valid_in,
  input  logic [ROB_WIDTH-1:0] cdb_tag_in,
  input  logic [31:0]          cdb_value_in,
  output logic [5:0]           alu_op_out,
  output logic [31:0]          alu_rs1_out,
  output logic [31:0]          alu_rs2_out,
  input  logic [31:0]          alu_result_in,
  input  logic                 alu_valid_in,
  output logic                 result_valid_out,
  output logic [ROB_WIDTH-1:0] result_tag_out,
  output logic [31:0]          result_value_out
);

  localparam int DATA_W = 32;
  localparam int OP_W   = 6;
  localparam int IDX_W  = $clog2(RS_SIZE);

  // Station entries; data fields are only meaningful while busy is set.
  logic [RS_SIZE-1:0]   ent_busy;
  logic [RS_SIZE-1:0]   ent_qj_busy;
  logic [RS_SIZE-1:0]   ent_qk_busy;
  logic [OP_W-1:0]      ent_op   [RS_SIZE];
  logic [DATA_W-1:0]    ent_vj   [RS_SIZE];
  logic [DATA_W-1:0]    ent_vk   [RS_SIZE];
  logic [ROB_WIDTH-1:0] ent_qj   [RS_SIZE];
  logic [ROB_WIDTH-1:0] ent_qk   [RS_SIZE];
  logic [ROB_WIDTH-1:0] ent_dest [RS_SIZE];

  // ALU input stage and result stage registers.
  logic [OP_W-1:0]      op_p1;
  logic [DATA_W-1:0]    rs1_p1;
  logic [DATA_W-1:0]    rs2_p1;
  logic [ROB_WIDTH-1:0] tag_p1;
  logic                 vld_p2;
  logic [ROB_WIDTH-1:0] tag_p2;
  logic [DATA_W-1:0]    value_p2;

  logic [RS_SIZE-1:0] ready;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               issue_fire;
  logic               byp_j;
  logic               byp_k;

  // Lowest-index ready and lowest-index free entry, from registered state only.
  always_comb begin
    ready      = ent_busy & ~ent_qj_busy & ~ent_qk_busy;
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!ent_busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Issue acceptance and same-cycle CDB bypass for the incoming operands.
  always_comb begin
    full_out   = &ent_busy;
    issue_fire = issue_valid_in && free_found;
    byp_j      = issue_qj_busy_in && cdb_valid_in && (issue_qj_in == cdb_tag_in);
    byp_k      = issue_qk_busy_in && cdb_valid_in && (issue_qk_in == cdb_tag_in);
  end

  // Entry state: CDB wakeup, release on dispatch, allocation on issue.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ent_busy <= '0;
    end else if (flush_in) begin
      ent_busy <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ent_busy[i] && cdb_valid_in) begin
          if (ent_qj_busy[i] && (ent_qj[i] == cdb_tag_in)) begin
            ent_vj[i]      <= cdb_value_in;
            ent_qj_busy[i] <= 1'b0;
          end
          if (ent_qk_busy[i] && (ent_qk[i] == cdb_tag_in)) begin
            ent_vk[i]      <= cdb_value_in;
            ent_qk_busy[i] <= 1'b0;
          end
        end
      end
      if (sel_found) begin
        ent_busy[sel_idx] <= 1'b0;
      end
      if (issue_fire) begin
        ent_busy[free_idx]    <= 1'b1;
        ent_op[free_idx]      <= issue_op_in;
        ent_qj[free_idx]      <= issue_qj_in;
        ent_qk[free_idx]      <= issue_qk_in;
        ent_dest[free_idx]    <= issue_dest_in;
        ent_vj[free_idx]      <= byp_j ? cdb_value_in : issue_vj_in;
        ent_vk[free_idx]      <= byp_k ? cdb_value_in : issue_vk_in;
        ent_qj_busy[free_idx] <= issue_qj_busy_in && !byp_j;
        ent_qk_busy[free_idx] <= issue_qk_busy_in && !byp_k;
      end
    end
  end

  // Stage p1: selected entry drives the ALU inputs; op 0 means the ALU idles.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      op_p1  <= '0;
      rs1_p1 <= '0;
      rs2_p1 <= '0;
      tag_p1 <= '0;
    end else if (flush_in) begin
      op_p1 <= '0;
    end else if (rdy_in) begin
      if (sel_found) begin
        op_p1  <= ent_op[sel_idx];
        rs1_p1 <= ent_vj[sel_idx];
        rs2_p1 <= ent_vk[sel_idx];
        tag_p1 <= ent_dest[sel_idx];
      end else begin
        op_p1 <= '0;
      end
    end
  end

  // Stage p2: ALU result captured with its ROB tag; a flush kills the slot.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_p2   <= 1'b0;
      tag_p2   <= '0;
      value_p2 <= '0;
    end else if (flush_in) begin
      vld_p2 <= 1'b0;
    end else if (rdy_in) begin
      vld_p2   <= alu_valid_in;
      tag_p2   <= tag_p1;
      value_p2 <= alu_result_in;
    end
  end

  assign alu_op_out       = op_p1;
  assign alu_rs1_out      = rs1_p1;
  assign alu_rs2_out      = rs2_p1;
  assign result_valid_out = vld_p2;
  assign result_tag_out   = tag_p2;
  assign result_value_out = value_p2;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Bench for alu_rs_scheduler: directed vector table, hand-written corner
// sequences and randomized traffic against an instruction-level model.
module tb_alu_rs_scheduler;

  localparam int RS = 8;
  localparam int RW = 4;

  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_SLTU = 6'd3;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_JAL  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd6;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, flush_in;
  logic          issue_valid_in;
  logic [5:0]    issue_op_in;
  logic [31:0]   issue_vj_in, issue_vk_in;
  logic [RW-1:0] issue_qj_in, issue_qk_in, issue_dest_in;
  logic          issue_qj_busy_in, issue_qk_busy_in;
  logic          full_out;
  logic          cdb_valid_in;
  logic [RW-1:0] cdb_tag_in;
  logic [31:0]   cdb_value_in;
  logic [5:0]    alu_op_out;
  logic [31:0]   alu_rs1_out, alu_rs2_out;
  logic [31:0]   alu_result_in;
  logic          alu_valid_in;
  logic          result_valid_out;
  logic [RW-1:0] result_tag_out;
  logic [31:0]   result_value_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  alu_rs_scheduler #(.RS_SIZE(RS), .ROB_WIDTH(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .issue_valid_in(issue_valid_in), .issue_op_in(issue_op_in),
    .issue_vj_in(issue_vj_in), .issue_qj_in(issue_qj_in),
    .issue_qj_busy_in(issue_qj_busy_in), .issue_vk_in(issue_vk_in),
    .issue_qk_in(issue_qk_in), .issue_qk_busy_in(issue_qk_busy_in),
    .issue_dest_in(issue_dest_in), .full_out(full_out),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_value_in(cdb_value_in),
    .alu_op_out(alu_op_out), .alu_rs1_out(alu_rs1_out), .alu_rs2_out(alu_rs2_out),
    .alu_result_in(alu_result_in), .alu_valid_in(alu_valid_in),
    .result_valid_out(result_valid_out), .result_tag_out(result_tag_out),
    .result_value_out(result_value_out)
  );

  // Behavioural ALU shared by the environment and the reference model.
  function automatic logic [31:0] alu_f(logic [5:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      OP_ADD, OP_ADDI: alu_f = a + b;
      OP_SUB:          alu_f = a - b;
      OP_SLTU:         alu_f = {31'b0, a < b};
      OP_BEQ:          alu_f = {31'b0, a == b};
      OP_JAL:          alu_f = b + 32'd4;
      default:         alu_f = a ^ b;
    endcase
  endfunction

  assign alu_valid_in  = (alu_op_out != 6'd0);
  assign alu_result_in = alu_f(alu_op_out, alu_rs1_out, alu_rs2_out);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          busy;
    logic [5:0]  op;
    logic [31:0] vj, vk;
    logic [3:0]  qj, qk, dest;
    bit          jb, kb;
  } ent_t;

  ent_t        m [RS];
  logic [5:0]  m_op;
  logic [31:0] m_rs1, m_rs2, m_rval;
  logic [3:0]  m_tag, m_rt;
  bit          m_rv;

  function automatic bit m_full();
    m_full = 1'b1;
    foreach (m[i]) if (!m[i].busy) m_full = 1'b0;
  endfunction

  task automatic model_edge();
    ent_t pre [RS];
    ent_t e;
    int   si;
    int   fi;
    if (rst_in) begin
      foreach (m[i]) m[i].busy = 1'b0;
      m_op = 0; m_rs1 = 0; m_rs2 = 0; m_tag = 0;
      m_rv = 0; m_rt = 0; m_rval = 0;
    end else if (flush_in) begin
      foreach (m[i]) m[i].busy = 1'b0;
      m_op = 0;
      m_rv = 0;
    end else if (rdy_in) begin
      pre = m;
      m_rv   = (m_op != 0);
      m_rval = alu_f(m_op, m_rs1, m_rs2);
      m_rt   = m_tag;
      si = -1;
      for (int i = 0; i < RS; i++)
        if (pre[i].busy && !pre[i].jb && !pre[i].kb) begin si = i; break; end
      if (si >= 0) begin
        m_op = pre[si].op; m_rs1 = pre[si].vj; m_rs2 = pre[si].vk; m_tag = pre[si].dest;
        m[si].busy = 1'b0;
      end else begin
        m_op = 0;
      end
      if (cdb_valid_in)
        for (int i = 0; i < RS; i++) if (pre[i].busy) begin
          if (pre[i].jb && pre[i].qj == cdb_tag_in) begin m[i].vj = cdb_value_in; m[i].jb = 0; end
          if (pre[i].kb && pre[i].qk == cdb_tag_in) begin m[i].vk = cdb_value_in; m[i].kb = 0; end
        end
      fi = -1;
      for (int i = 0; i < RS; i++) if (!pre[i].busy) begin fi = i; break; end
      if (issue_valid_in && fi >= 0) begin
        e.busy = 1'b1; e.op = issue_op_in; e.dest = issue_dest_in;
        e.qj = issue_qj_in; e.qk = issue_qk_in;
        if (issue_qj_busy_in && cdb_valid_in && issue_qj_in == cdb_tag_in) begin
          e.vj = cdb_value_in; e.jb = 0;
        end else begin
          e.vj = issue_vj_in; e.jb = issue_qj_busy_in;
        end
        if (issue_qk_busy_in && cdb_valid_in && issue_qk_in == cdb_tag_in) begin
          e.vk = cdb_value_in; e.kb = 0;
        end else begin
          e.vk = issue_vk_in; e.kb = issue_qk_busy_in;
        end
        m[fi] = e;
      end
    end
  endtask

  task automatic idle();
    rst_in = 0; rdy_in = 1; flush_in = 0;
    issue_valid_in = 0; issue_op_in = 0; issue_vj_in = 0; issue_vk_in = 0;
    issue_qj_in = 0; issue_qk_in = 0; issue_qj_busy_in = 0; issue_qk_busy_in = 0;
    issue_dest_in = 0; cdb_valid_in = 0; cdb_tag_in = 0; cdb_value_in = 0;
  endtask

  task automatic set_issue(logic [5:0] op, logic [31:0] vj, bit jb, logic [3:0] qj,
                           logic [31:0] vk, bit kb, logic [3:0] qk, logic [3:0] dest);
    issue_valid_in = 1; issue_op_in = op;
    issue_vj_in = vj; issue_qj_busy_in = jb; issue_qj_in = qj;
    issue_vk_in = vk; issue_qk_busy_in = kb; issue_qk_in = qk;
    issue_dest_in = dest;
  endtask

  // One clock edge; the model advances on the same inputs, then outputs are checked.
  task automatic step(bit cmp);
    @(posedge clk_in);
    model_edge();
    #1;
    if (cmp) begin
      chk("full", full_out, m_full());
      chk("alu_op", alu_op_out, m_op);
      if (m_op != 0) begin
        chk("alu_rs1", alu_rs1_out, m_rs1);
        chk("alu_rs2", alu_rs2_out, m_rs2);
      end
      chk("res_valid", result_valid_out, m_rv);
      if (m_rv) begin
        chk("res_tag", result_tag_out, m_rt);
        chk("res_value", result_value_out, m_rval);
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          iv;
    logic [5:0]  op;
    logic [31:0] vj;  bit qjb; logic [3:0] qj;
    logic [31:0] vk;  bit qkb; logic [3:0] qk;
    logic [3:0]  dest;
    bit          cv;  logic [3:0] ct; logic [31:0] cval;
    logic [5:0]  e_op;
    bit          e_rv; logic [3:0] e_tag; logic [31:0] e_val;
  } vec_t;

  function automatic vec_t rw(bit iv, logic [5:0] op, logic [31:0] vj, bit qjb, logic [3:0] qj,
                              logic [31:0] vk, bit qkb, logic [3:0] qk, logic [3:0] dest,
                              bit cv, logic [3:0] ct, logic [31:0] cval,
                              logic [5:0] e_op, bit e_rv, logic [3:0] e_tag, logic [31:0] e_val);
    rw.iv = iv; rw.op = op; rw.vj = vj; rw.qjb = qjb; rw.qj = qj;
    rw.vk = vk; rw.qkb = qkb; rw.qk = qk; rw.dest = dest;
    rw.cv = cv; rw.ct = ct; rw.cval = cval;
    rw.e_op = e_op; rw.e_rv = e_rv; rw.e_tag = e_tag; rw.e_val = e_val;
  endfunction

  vec_t tbl [21];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // inputs                                   iss j/k/dest                cdb           expected op/rv/tag/val
    tbl[0]  = rw(1, OP_ADDI, 5, 0, 0,   7, 0, 0, 3,   0, 0, 0,             0,       0, 0, 0);
    tbl[1]  = rw(0, 0,       0, 0, 0,   0, 0, 0, 0,   0, 0, 0,             OP_ADDI, 0, 0, 0);
    tbl[2]  = rw(0, 0,       0, 0, 0,   0, 0, 0, 0,   0, 0, 0,             0,       1, 3, 12);
    tbl[3]  = rw(1, OP_ADD,  0, 1, 2,   1, 0, 0, 5,   0, 0, 0,             0,       0, 0, 0);
    tbl[4]  = rw(0, 0,       0, 0, 0,   0, 0, 0, 0,   1, 3, 99,            0,       0, 0, 0);
    tbl[5]  = rw(0, 0,       0, 0, 0,   0, 0, 0, 0,   1, 2, 10,            0,       0, 0, 0);
    tbl[6]  = rw(0, 0,       0, 0, 0,   0, 0, 0, 0,   0, 0, 0,             OP_ADD,  0, 0, 0);
    tbl[7]  = rw(0, 0,       0, 0, 0,   0, 0, 0, 0,   0, 0, 0,             0,       1, 5, 11);
    tbl[8]  = rw(1, OP_SLTU, 0, 1, 4,   1, 0, 0, 7,   1, 4, 32'hFFFF_FFFF, 0,       0, 0, 0);
    tbl[9]  = rw(0, 0,       0, 0, 0,   0, 0, 0, 0,   0, 0, 0,             OP_SLTU, 0, 0, 0);
    tbl[10] = rw(0, 0,       0, 0, 0,   0, 0, 0, 0,   0, 0, 0,             0,       1, 7, 0);
    tbl[11] = rw(1, OP_SUB,  0, 1, 9,   0, 1, 9, 2,   0, 0, 0,             0,       0, 0, 0);
    tbl[12] = rw(0, 0,       0, 0, 0,   0, 0, 0, 0,   1, 9, 20,            0,       0, 0, 0);
    tbl[13] = rw(0, 0,       0, 0, 0,   0, 0, 0, 0,   0, 0, 0,             OP_SUB,  0, 0, 0);
    tbl[14] = rw(0, 0,       0, 0, 0,   0, 0, 0, 0,   0, 0, 0,             0,       1, 2, 0);
    tbl[15] = rw(1, OP_JAL,  100, 0, 0, 200, 0, 0, 1, 0, 0, 0,             0,       0, 0, 0);
    tbl[16] = rw(0, 0,       0, 0, 0,   0, 0, 0, 0,   0, 0, 0,             OP_JAL,  0, 0, 0);
    tbl[17] = rw(0, 0,       0, 0, 0,   0, 0, 0, 0,   0, 0, 0,             0,       1, 1, 204);
    tbl[18] = rw(1, OP_BEQ,  9, 0, 0,   9, 0, 0, 6,   0, 0, 0,             0,       0, 0, 0);
    tbl[19] = rw(0, 0,       0, 0, 0,   0, 0, 0, 0,   0, 0, 0,             OP_BEQ,  0, 0, 0);
    tbl[20] = rw(0, 0,       0, 0, 0,   0, 0, 0, 0,   0, 0, 0,             0,       1, 6, 1);

    // Reset state
    idle();
    rst_in = 1;
    step(0);
    step(0);
    chk("rst_full", full_out, 0);
    chk("rst_alu_op", alu_op_out, 0);
    chk("rst_rs1", alu_rs1_out, 0);
    chk("rst_rs2", alu_rs2_out, 0);
    chk("rst_res_valid", result_valid_out, 0);
    chk("rst_res_tag", result_tag_out, 0);
    chk("rst_res_value", result_value_out, 0);
    rst_in = 0;

    // Directed table
    for (int r = 0; r < 21; r++) begin
      idle();
      issue_valid_in = tbl[r].iv; issue_op_in = tbl[r].op;
      issue_vj_in = tbl[r].vj; issue_qj_busy_in = tbl[r].qjb; issue_qj_in = tbl[r].qj;
      issue_vk_in = tbl[r].vk; issue_qk_busy_in = tbl[r].qkb; issue_qk_in = tbl[r].qk;
      issue_dest_in = tbl[r].dest;
      cdb_valid_in = tbl[r].cv; cdb_tag_in = tbl[r].ct; cdb_value_in = tbl[r].cval;
      step(0);
      chk($sformatf("tbl%0d_op", r), alu_op_out, tbl[r].e_op);
      chk($sformatf("tbl%0d_rv", r), result_valid_out, tbl[r].e_rv);
      if (tbl[r].e_rv) begin
        chk($sformatf("tbl%0d_tag", r), result_tag_out, tbl[r].e_tag);
        chk($sformatf("tbl%0d_val", r), result_value_out, tbl[r].e_val);
      end
    end

    // Re-sync model and DUT
    idle();
    rst_in = 1;
    step(1);
    rst_in = 0;

    // Fill all entries with operands waiting on tag 15
    for (int k = 0; k < RS; k++) begin
      idle();
      set_issue(OP_ADD, 0, 1, 15, 32'(k + 1), 0, 0, 4'(k));
      step(1);
    end
    chk("full_set", full_out, 1);
    idle();
    set_issue(OP_ADD, 1, 0, 0, 1, 0, 0, 9);
    step(1);
    chk("ninth_ignored_full", full_out, 1);
    chk("ninth_not_dispatched", alu_op_out, 0);
    idle();
    cdb_valid_in = 1; cdb_tag_in = 15; cdb_value_in = 100;
    step(1);
    chk("capture_no_dispatch", alu_op_out, 0);
    idle();
    set_issue(OP_SUB, 1, 0, 0, 1, 0, 0, 10);
    step(1);
    chk("full_drop", full_out, 0);
    chk("first_dispatch_rs1", alu_rs1_out, 100);
    chk("first_dispatch_rs2", alu_rs2_out, 1);
    idle();
    step(1);
    chk("lowest_first_tag", result_tag_out, 0);
    for (int k = 0; k < 10; k++) begin idle(); step(1); end

    // Flush with pending entries and an op in the ALU stage
    for (int k = 0; k < 3; k++) begin
      idle();
      set_issue(OP_ADD, 0, 1, 14, 3, 0, 0, 4'(12 + k));
      step(1);
    end
    idle();
    set_issue(OP_ADD, 40, 0, 0, 2, 0, 0, 11);
    step(1);
    idle();
    step(1);
    chk("pre_flush_op", alu_op_out, OP_ADD);
    idle();
    flush_in = 1;
    set_issue(OP_ADD, 1, 0, 0, 1, 0, 0, 8);
    step(1);
    chk("flush_op", alu_op_out, 0);
    chk("flush_rv", result_valid_out, 0);
    chk("flush_full", full_out, 0);
    idle();
    cdb_valid_in = 1; cdb_tag_in = 14; cdb_value_in = 5;
    step(1);
    for (int k = 0; k < 3; k++) begin
      idle();
      step(1);
      chk("post_flush_rv", result_valid_out, 0);
      chk("post_flush_op", alu_op_out, 0);
    end

    // rdy_in low freezes a ready entry
    idle();
    set_issue(OP_SUB, 50, 0, 0, 8, 0, 0, 12);
    step(1);
    for (int k = 0; k < 3; k++) begin
      idle();
      rdy_in = 0;
      step(1);
      chk("stall_op", alu_op_out, 0);
    end
    idle();
    step(1);
    chk("resume_op", alu_op_out, OP_SUB);
    idle();
    step(1);
    chk("resume_rv", result_valid_out, 1);
    chk("resume_val", result_value_out, 42);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst_in   = ($urandom_range(0, 499) == 0);
      flush_in = ($urandom_range(0, 99) == 0);
      rdy_in   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 1) begin
        set_issue(6'($urandom_range(1, 7)), $urandom, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20)),
                  $urandom_range(0, 2) == 0, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      end
      cdb_valid_in = ($urandom_range(0, 4) < 2);
      cdb_tag_in   = 4'($urandom_range(0, 7));
      cdb_value_in = $urandom;
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
